// File: rtl/mem_wb_skid_pipe.sv
// rtl/mem_wb_skid_pipe.sv - MEM->WB pipeline register with a 2-entry skid buffer, flush and retire counter
// Optional register-file forwarding taps are built when MEM_WB_BYPASS_EN is defined.
module mem_wb_skid_pipe #(
  parameter int DATA_WIDTH  = 24,
  parameter int DEST_WIDTH  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   writeback_enable,
  input  logic                   mem_read_enable,
  input  logic [DEST_WIDTH-1:0]  instruction_dest,
  input  logic [DATA_WIDTH-1:0]  mem_read_data,
  input  logic [DATA_WIDTH-1:0]  alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   writeback_enable_out,
  output logic [DEST_WIDTH-1:0]  instruction_dest_out,
  output logic [DATA_WIDTH-1:0]  writeback_data_out,
  output logic [COUNT_WIDTH-1:0] retire_count
`ifdef MEM_WB_BYPASS_EN
  ,
  input  logic [DEST_WIDTH-1:0]  fwd_src_reg,
  output logic                   fwd_hit,
  output logic [DATA_WIDTH-1:0]  fwd_data
`endif
);

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

  state_t                state, state_next;
  logic                  head_wb, skid_wb;
  logic [DEST_WIDTH-1:0] head_dest, skid_dest;
  logic [DATA_WIDTH-1:0] head_data, skid_data;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  accept, drain;
  logic                  load_head_in, load_head_skid, load_skid;

  // in_ready is a pure function of state so out_ready never reaches it combinationally.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign in_data   = mem_read_enable ? mem_read_data : alu_result;

  always_comb begin
    state_next     = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next   = HALF;
          load_head_in = 1'b1;
        end
      end
      HALF: begin
        if (accept && drain) begin
          load_head_in = 1'b1;
        end else if (accept) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (drain) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_next     = HALF;
          load_head_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      head_wb      <= 1'b0;
      head_dest    <= '0;
      head_data    <= '0;
      skid_wb      <= 1'b0;
      skid_dest    <= '0;
      skid_data    <= '0;
      retire_count <= '0;
    end else begin
      // A drain coinciding with flush still retires: WB already consumed it.
      if (drain && head_wb) retire_count <= retire_count + COUNT_WIDTH'(1);
      if (flush) begin
        state     <= EMPTY;
        head_wb   <= 1'b0;
        head_dest <= '0;
        head_data <= '0;
        skid_wb   <= 1'b0;
        skid_dest <= '0;
        skid_data <= '0;
      end else begin
        state <= state_next;
        if (load_head_in) begin
          head_wb   <= writeback_enable;
          head_dest <= instruction_dest;
          head_data <= in_data;
        end else if (load_head_skid) begin
          head_wb   <= skid_wb;
          head_dest <= skid_dest;
          head_data <= skid_data;
        end
        if (load_skid) begin
          skid_wb   <= writeback_enable;
          skid_dest <= instruction_dest;
          skid_data <= in_data;
        end
      end
    end
  end

  assign writeback_enable_out = out_valid & head_wb;
  assign instruction_dest_out = out_valid ? head_dest : '0;
  assign writeback_data_out   = out_valid ? head_data : '0;

`ifdef MEM_WB_BYPASS_EN
  logic skid_hit, head_hit;

  // The skid entry is younger than head, so it wins when both match.
  assign skid_hit = (state == FULL) && skid_wb && (skid_dest == fwd_src_reg) && (skid_dest != '0);
  assign head_hit = out_valid && head_wb && (head_dest == fwd_src_reg) && (head_dest != '0);
  assign fwd_hit  = skid_hit | head_hit;
  assign fwd_data = skid_hit ? skid_data : (head_hit ? head_data : '0);
`endif

endmodule

// File: tb/tb_mem_wb_skid_pipe.sv
// tb/tb_mem_wb_skid_pipe.sv - table-driven checks of mem_wb_skid_pipe with a 3-bit retire counter
module tb_mem_wb_skid_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic        writeback_enable, mem_read_enable;
  logic [3:0]  instruction_dest;
  logic [23:0] mem_read_data, alu_result;
  logic        out_valid, out_ready, writeback_enable_out;
  logic [3:0]  instruction_dest_out;
  logic [23:0] writeback_data_out;
  logic [2:0]  retire_count;
`ifdef MEM_WB_BYPASS_EN
  logic [3:0]  fwd_src_reg;
  logic        fwd_hit;
  logic [23:0] fwd_data;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_wb_skid_pipe #(.DATA_WIDTH(24), .DEST_WIDTH(4), .COUNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .writeback_enable(writeback_enable), .mem_read_enable(mem_read_enable),
    .instruction_dest(instruction_dest), .mem_read_data(mem_read_data),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .writeback_enable_out(writeback_enable_out), .instruction_dest_out(instruction_dest_out),
    .writeback_data_out(writeback_data_out), .retire_count(retire_count)
`ifdef MEM_WB_BYPASS_EN
    , .fwd_src_reg(fwd_src_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  typedef struct {
    logic        fl, iv, wb, mre;
    logic [3:0]  dest;
    logic [23:0] mem, alu;
    logic        ordy;
    logic        irdy, ov, wbo;
    logic [3:0]  desto;
    logic [23:0] datao;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic fl, iv, wb, mre, input logic [3:0] dest,
                             input logic [23:0] mem, alu, input logic ordy,
                             input logic irdy, ov, wbo, input logic [3:0] desto,
                             input logic [23:0] datao, input logic [2:0] cnt);
    vec_t r;
    r.fl = fl; r.iv = iv; r.wb = wb; r.mre = mre; r.dest = dest; r.mem = mem; r.alu = alu;
    r.ordy = ordy; r.irdy = irdy; r.ov = ov; r.wbo = wbo; r.desto = desto; r.datao = datao;
    r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic fl, iv, wb, mre, input logic [3:0] dest,
                       input logic [23:0] mem, alu, input logic ordy);
    @(negedge clk);
    flush = fl; in_valid = iv; writeback_enable = wb; mem_read_enable = mre;
    instruction_dest = dest; mem_read_data = mem; alu_result = alu; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string p, input logic irdy, ov, wbo, input logic [3:0] desto,
                          input logic [23:0] datao, input logic [2:0] cnt);
    chk({p, "_in_ready"}, 32'(in_ready), 32'(irdy));
    chk({p, "_out_valid"}, 32'(out_valid), 32'(ov));
    chk({p, "_wb_out"}, 32'(writeback_enable_out), 32'(wbo));
    chk({p, "_dest_out"}, 32'(instruction_dest_out), 32'(desto));
    chk({p, "_data_out"}, 32'(writeback_data_out), 32'(datao));
    chk({p, "_retire"}, 32'(retire_count), 32'(cnt));
  endtask

  task automatic do_reset(input logic iv, input logic ordy);
    @(negedge clk);
    rst = 1'b1; in_valid = iv; out_ready = ordy; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 0; in_valid = 0; writeback_enable = 0; mem_read_enable = 0;
    instruction_dest = 0; mem_read_data = 0; alu_result = 0; out_ready = 0;
`ifdef MEM_WB_BYPASS_EN
    fwd_src_reg = 0;
`endif

    //        fl iv wb mre dest mem        alu        ordy | irdy ov wbo desto datao     cnt
    tbl.push_back(v(0, 1, 1, 0, 4'd3,  24'h111111, 24'h00ABCD, 1, 1, 1, 1, 4'd3,  24'h00ABCD, 3'd0));
    tbl.push_back(v(0, 0, 0, 0, 4'd0,  24'h0,      24'h0,      1, 1, 0, 0, 4'd0,  24'h0,      3'd1));
    tbl.push_back(v(0, 1, 1, 1, 4'd5,  24'hFEDCBA, 24'h000001, 1, 1, 1, 1, 4'd5,  24'hFEDCBA, 3'd1));
    tbl.push_back(v(0, 0, 0, 0, 4'd0,  24'h0,      24'h0,      0, 1, 1, 1, 4'd5,  24'hFEDCBA, 3'd1));
    tbl.push_back(v(0, 0, 0, 0, 4'd0,  24'h0,      24'h0,      1, 1, 0, 0, 4'd0,  24'h0,      3'd2));
    tbl.push_back(v(0, 1, 1, 0, 4'd1,  24'h0,      24'h00000A, 0, 1, 1, 1, 4'd1,  24'h00000A, 3'd2));
    tbl.push_back(v(0, 1, 1, 0, 4'd2,  24'h0,      24'h00000B, 0, 0, 1, 1, 4'd1,  24'h00000A, 3'd2));
    tbl.push_back(v(0, 1, 1, 0, 4'd7,  24'h0,      24'h00000C, 0, 0, 1, 1, 4'd1,  24'h00000A, 3'd2));
    tbl.push_back(v(0, 0, 0, 0, 4'd0,  24'h0,      24'h0,      1, 1, 1, 1, 4'd2,  24'h00000B, 3'd3));
    tbl.push_back(v(0, 0, 0, 0, 4'd0,  24'h0,      24'h0,      1, 1, 0, 0, 4'd0,  24'h0,      3'd4));
    tbl.push_back(v(0, 1, 0, 0, 4'd6,  24'h0,      24'h000066, 0, 1, 1, 0, 4'd6,  24'h000066, 3'd4));
    tbl.push_back(v(0, 0, 0, 0, 4'd0,  24'h0,      24'h0,      1, 1, 0, 0, 4'd0,  24'h0,      3'd4));
    tbl.push_back(v(0, 1, 1, 0, 4'd8,  24'h0,      24'h000111, 0, 1, 1, 1, 4'd8,  24'h000111, 3'd4));
    tbl.push_back(v(0, 1, 1, 0, 4'd9,  24'h0,      24'h000222, 0, 0, 1, 1, 4'd8,  24'h000111, 3'd4));
    tbl.push_back(v(1, 1, 1, 0, 4'd10, 24'h0,      24'h000333, 0, 1, 0, 0, 4'd0,  24'h0,      3'd4));
    tbl.push_back(v(0, 1, 1, 0, 4'd11, 24'h0,      24'h000444, 0, 1, 1, 1, 4'd11, 24'h000444, 3'd4));
    tbl.push_back(v(1, 1, 1, 0, 4'd12, 24'h0,      24'h000555, 1, 1, 0, 0, 4'd0,  24'h0,      3'd5));
    tbl.push_back(v(0, 0, 0, 0, 4'd0,  24'h0,      24'h0,      0, 1, 0, 0, 4'd0,  24'h0,      3'd5));

    do_reset(1'b0, 1'b0);
    chk_outs("reset", 1, 0, 0, 4'd0, 24'h0, 3'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].wb, tbl[i].mre, tbl[i].dest, tbl[i].mem, tbl[i].alu,
            tbl[i].ordy);
      chk_outs($sformatf("v%0d", i), tbl[i].irdy, tbl[i].ov, tbl[i].wbo, tbl[i].desto,
               tbl[i].datao, tbl[i].cnt);
    end

    // Reset while FULL with live handshakes: everything clears, counter included.
    drive(0, 1, 1, 0, 4'd13, 24'h0, 24'h000777, 0);
    drive(0, 1, 1, 0, 4'd14, 24'h0, 24'h000888, 0);
    chk("full_before_rst", 32'(in_ready), 32'd0);
    do_reset(1'b1, 1'b1);
    chk_outs("mid_rst", 1, 0, 0, 4'd0, 24'h0, 3'd0);

    // Streaming at full rate; 8 retirements wrap the 3-bit counter back to 0.
    for (int k = 1; k <= 8; k++) begin
      drive(0, 1, 1, 0, 4'(k), 24'h0, 24'(k * 256), 1);
      chk_outs($sformatf("stream%0d", k), 1, 1, 1, 4'(k), 24'(k * 256), 3'(k - 1));
    end
    drive(0, 0, 0, 0, 4'd0, 24'h0, 24'h0, 1);
    chk_outs("stream_end", 1, 0, 0, 4'd0, 24'h0, 3'd0);

`ifdef MEM_WB_BYPASS_EN
    drive(0, 1, 1, 0, 4'd4, 24'h0, 24'h000010, 0);
    drive(0, 1, 1, 0, 4'd4, 24'h0, 24'h000020, 0);
    in_valid = 1'b0;
    fwd_src_reg = 4'd4;
    #1;
    chk("fwd_hit_newest", 32'(fwd_hit), 32'd1);
    chk("fwd_data_newest", 32'(fwd_data), 32'h000020);
    fwd_src_reg = 4'd0;
    #1;
    chk("fwd_hit_r0", 32'(fwd_hit), 32'd0);
    chk("fwd_data_r0", 32'(fwd_data), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid_pipe.md
Name: mem_wb_skid_pipe

Overview:
- Parametrised successor to the fixed-width MEM→WB pipeline register.
- Sits between memory_stage outputs and writeback_stage inputs.
- Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, and writeback-data selection at capture.
- Adds a retired-writeback counter and optional register-file forwarding taps.

Parameters:
- DATA_WIDTH, 24, width of mem_read_data, alu_result and writeback_data_out.
- DEST_WIDTH, 4, width of the destination register index.
- COUNT_WIDTH, 16, width of retire_count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  upstream (MEM) entry valid.
- in_ready  output  1  block can accept an entry this cycle.
- writeback_enable  input  1  entry writes the register file.
- mem_read_enable  input  1  selects mem_read_data (1) or alu_result (0).
- instruction_dest  input  DEST_WIDTH  destination register.
- mem_read_data  input  DATA_WIDTH  load data.
- alu_result  input  DATA_WIDTH  ALU data.
- out_valid  output  1  head entry presented to WB.
- out_ready  input  1  WB consumes the head entry this cycle.
- writeback_enable_out  output  1  head writeback enable, gated by out_valid.
- instruction_dest_out  output  DEST_WIDTH  head destination.
- writeback_data_out  output  DATA_WIDTH  head resolved writeback data.
- retire_count  output  COUNT_WIDTH  count of drained entries with writeback enabled.

Behaviour:
- Handshake events: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Capture stores {writeback_enable, instruction_dest, data}, where data = mem_read_enable ? mem_read_data : alu_result. The data mux is resolved at capture, not at output.
- Storage: head register and skid register. FSM states EMPTY, HALF, FULL.
- in_ready = (state != FULL). It depends only on state; no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Transitions, when flush = 0:
  - EMPTY: accept → HALF, head ← input.
  - HALF: accept & !drain → FULL, skid ← input.
  - HALF: !accept & drain → EMPTY.
  - HALF: accept & drain → HALF, head ← input.
  - HALF: neither → HALF, hold.
  - FULL: drain → HALF, head ← skid. No accept is possible (in_ready = 0).
  - FULL: !drain → hold.
- Ordering: strict FIFO, never reordered, never duplicated.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput is 1 entry/cycle while out_ready = 1.
- Outputs when EMPTY: writeback_enable_out, instruction_dest_out and writeback_data_out are driven 0.
- Entries with writeback_enable = 0 still occupy a slot and are drained normally as bubbles.
- retire_count: +1 on each drain whose head writeback_enable = 1. Wraps modulo 2^COUNT_WIDTH. Unaffected by flush.
- flush: next state EMPTY and head/skid cleared. Flush beats a same-cycle accept (input dropped) and a same-cycle drain (that drain still counts toward retire_count, since WB consumed it).
- rst: state EMPTY, head/skid zero, retire_count 0. Takes precedence over flush and all handshakes, including mid-transfer. in_ready = 1 in the cycle after rst deasserts.

Optional Feature:
- Macro: MEM_WB_BYPASS_EN.
- When defined, adds these ports:
  - fwd_src_reg  input  DEST_WIDTH
  - fwd_hit  output  1
  - fwd_data  output  DATA_WIDTH
- Forwarding lookup is combinational over valid entries with writeback_enable = 1, instruction_dest == fwd_src_reg, and instruction_dest != 0.
  - The newest entry (skid when FULL) takes priority over head.
  - fwd_hit = 1 and fwd_data = the matching entry's data; otherwise fwd_hit = 0 and fwd_data = 0.
- When undefined, these ports and their logic do not exist.

Test Plan:
- Reset, then one entry {wb=1, mre=0, dest=3, alu=24'h00ABCD, mem=24'h111111}, out_ready = 1 → next cycle out_valid = 1, dest_out = 3, data_out = 24'h00ABCD; retire_count = 1 after the drain.
- Load entry {wb=1, mre=1, dest=5, mem=24'hFEDCBA} → data_out = 24'hFEDCBA.
- out_ready = 0, push A (dest=1) and B (dest=2) → FULL, in_ready = 0, third push ignored. Raise out_ready → A then B appear on consecutive cycles; in_ready = 1 in the cycle after A drains.
- Streaming 8 entries with in_valid = out_ready = 1 → 8 consecutive out_valid cycles in order; retire_count = 8 (wrap check with COUNT_WIDTH = 3 gives 0).
- FULL plus flush asserted together with in_valid → next cycle out_valid = 0, all outputs 0, in_ready = 1, retire_count unchanged.
- With MEM_WB_BYPASS_EN, head {dest=4, data=24'h000010} and skid {dest=4, data=24'h000020}, fwd_src_reg = 4 → fwd_hit = 1, fwd_data = 24'h000020. fwd_src_reg = 0 → fwd_hit = 0.
